// File: rtl/axi_burst_master.sv
// AXI4 burst master: one INCR read or write burst per command, with a merged completion response.
// Optional handshake watchdog and done_timeout port when AXI_BURST_MASTER_TIMEOUT_EN is defined.
module axi_burst_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_BURST_LEN  = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
    output logic                    done_timeout,
`endif
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic                    wr_data_valid,
    output logic                    wr_data_ready,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    output logic                    rd_data_valid,
    input  logic                    rd_data_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_data_last,
    output logic                    done_valid,
    output logic [1:0]              done_resp,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [2:0] AXSIZE = 3'($clog2(STRB_W));

    if ((DATA_WIDTH != 32 && DATA_WIDTH != 64) || MAX_BURST_LEN < 1 ||
        MAX_BURST_LEN > 256 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("axi_burst_master: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_WADDR, S_WDATA, S_WRESP, S_RADDR, S_RDATA, S_DONE
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [7:0]              len_reg;
    logic [8:0]              beat_cnt_reg;
    logic [1:0]              resp_reg;
    logic                    timeout_reg;

    logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic len_bad, beat_is_last, timeout_hit;
    logic [1:0] r_merged;

    assign cmd_hs       = (state_reg == S_IDLE) && cmd_valid;
    assign aw_hs        = (state_reg == S_WADDR) && awready;
    assign w_hs         = (state_reg == S_WDATA) && wr_data_valid && wready;
    assign b_hs         = (state_reg == S_WRESP) && bvalid;
    assign ar_hs        = (state_reg == S_RADDR) && arready;
    assign r_hs         = (state_reg == S_RDATA) && rvalid && rd_data_ready;
    assign len_bad      = ({1'b0, cmd_len} >= 9'(MAX_BURST_LEN));
    assign beat_is_last = (beat_cnt_reg == {1'b0, len_reg});

    // Sticky-worst merge; an rlast that disagrees with the beat count forces SLVERR.
    always_comb begin
        r_merged = resp_reg;
        if (rresp > r_merged) r_merged = rresp;
        if ((rlast != beat_is_last) && (r_merged < 2'b10)) r_merged = 2'b10;
    end

`ifdef AXI_BURST_MASTER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] timer_reg;
    logic             wait_state, chan_hs;

    assign wait_state  = (state_reg == S_WADDR) || (state_reg == S_WDATA) ||
                         (state_reg == S_WRESP) || (state_reg == S_RADDR) ||
                         (state_reg == S_RDATA);
    assign chan_hs     = aw_hs || w_hs || b_hs || ar_hs || r_hs;
    assign timeout_hit = wait_state && !chan_hs && (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || !wait_state || chan_hs) begin
            timer_reg <= '0;
        end else if (!timeout_hit) begin
            timer_reg <= timer_reg + 1'b1;
        end
    end

    assign done_timeout = (state_reg == S_DONE) && timeout_reg;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (cmd_valid) state_next = len_bad ? S_DONE : (cmd_write ? S_WADDR : S_RADDR);
            S_WADDR: if (aw_hs) state_next = S_WDATA;
            S_WDATA: if (w_hs && beat_is_last) state_next = S_WRESP;
            S_WRESP: if (b_hs) state_next = S_DONE;
            S_RADDR: if (ar_hs) state_next = S_RDATA;
            S_RDATA: if (r_hs && rlast) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (timeout_hit) state_next = S_DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_reg     <= '0;
            len_reg      <= '0;
            beat_cnt_reg <= '0;
            resp_reg     <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            if (cmd_hs) begin
                addr_reg     <= cmd_addr;
                len_reg      <= cmd_len;
                beat_cnt_reg <= '0;
                resp_reg     <= len_bad ? 2'b10 : 2'b00;
                timeout_reg  <= 1'b0;
            end
            if (w_hs || r_hs) beat_cnt_reg <= beat_cnt_reg + 1'b1;
            if (b_hs)         resp_reg     <= bresp;
            if (r_hs)         resp_reg     <= r_merged;
            if (timeout_hit) begin
                resp_reg    <= 2'b10;
                timeout_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        cmd_ready     = (state_reg == S_IDLE);
        awvalid       = (state_reg == S_WADDR);
        wvalid        = (state_reg == S_WDATA) && wr_data_valid;
        wr_data_ready = (state_reg == S_WDATA) && wready;
        wlast         = (state_reg == S_WDATA) && beat_is_last;
        bready        = (state_reg == S_WRESP);
        arvalid       = (state_reg == S_RADDR);
        rready        = (state_reg == S_RDATA) && rd_data_ready;
        rd_data_valid = (state_reg == S_RDATA) && rvalid;
        rd_data_last  = (state_reg == S_RDATA) && rlast;
        done_valid    = (state_reg == S_DONE);
        done_resp     = resp_reg;
        awaddr        = addr_reg;
        araddr        = addr_reg;
        awlen         = len_reg;
        arlen         = len_reg;
        awsize        = AXSIZE;
        arsize        = AXSIZE;
        awburst       = 2'b01;
        arburst       = 2'b01;
        wdata         = wr_data;
        wstrb         = wr_strb;
        rd_data       = rdata;
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Scoreboard bench for axi_burst_master: directed bursts against a simple AXI slave model.
// Expected channel traffic is queued per command and checked by an independent monitor.
module tb_axi_burst_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_data_valid, wr_data_ready;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        rd_data_valid, rd_data_ready, rd_data_last;
    logic [31:0] rd_data;
    logic        done_valid;
    logic [1:0]  done_resp;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [3:0]  wstrb;
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
    logic        done_timeout;
`endif

    always #5 clk = ~clk;

    axi_burst_master dut (
        .clk(clk), .rst_n(rst_n),
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
        .done_timeout(done_timeout),
`endif
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
        .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
        .rd_data(rd_data), .rd_data_last(rd_data_last),
        .done_valid(done_valid), .done_resp(done_resp),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;

    logic [39:0] exp_aw_q[$];   // {addr, len}
    logic [39:0] exp_ar_q[$];
    logic [36:0] exp_w_q[$];    // {data, strb, last}
    logic [32:0] exp_rd_q[$];   // {data, last}
    logic [2:0]  exp_done_q[$]; // {timeout, resp}
    logic [35:0] wd_q[$];       // write-data source {data, strb}

    // slave / sink configuration
    logic        aw_ready_cfg = 1'b1;
    logic        w_toggle = 1'b0;
    logic [1:0]  b_resp_cfg = 2'b00;
    int          r_beats = 1;
    int          r_err_beat = -1;
    logic [31:0] r_base = 32'h0;
    int          stall_at = -1;
    int          rd_beat = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // AXI slave model
    initial begin : slave
        logic w_last_hs, b_hs, ar_hs, r_hs;
        int   r_idx;
        logic r_active;
        r_idx = 0; r_active = 1'b0;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b1; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
        forever begin
            @(negedge clk);
            w_last_hs = wvalid && wready && wlast;
            b_hs      = bvalid && bready;
            ar_hs     = arvalid && arready;
            r_hs      = rvalid && rready;
            @(posedge clk); #1;
            awready = aw_ready_cfg;
            wready  = w_toggle ? ~wready : 1'b1;
            if (!rst_n) begin
                bvalid = 1'b0; r_active = 1'b0; r_idx = 0;
            end else begin
                if (b_hs) bvalid = 1'b0;
                if (w_last_hs) begin bvalid = 1'b1; bresp = b_resp_cfg; end
                if (ar_hs) begin
                    r_active = 1'b1; r_idx = 0;
                end else if (r_hs) begin
                    if (r_idx == r_beats - 1) r_active = 1'b0;
                    else r_idx++;
                end
            end
            rvalid = r_active;
            rdata  = r_base + 32'(r_idx);
            rresp  = (r_idx == r_err_beat) ? 2'b10 : 2'b00;
            rlast  = (r_idx == r_beats - 1);
        end
    end

    // write-data source
    initial begin : wsrc
        logic pop_w;
        wr_data_valid = 1'b0; wr_data = '0; wr_strb = '0;
        forever begin
            @(negedge clk);
            pop_w = wr_data_valid && wr_data_ready;
            @(posedge clk); #1;
            if (pop_w && wd_q.size() > 0) void'(wd_q.pop_front());
            wr_data_valid = (wd_q.size() > 0);
            if (wd_q.size() > 0) {wr_data, wr_strb} = wd_q[0];
        end
    end

    // read-data sink with an optional two-cycle stall
    initial begin : rsink
        logic hs, arhs;
        int   stall_left;
        stall_left = 0;
        rd_data_ready = 1'b1;
        forever begin
            @(negedge clk);
            hs   = rd_data_valid && rd_data_ready;
            arhs = arvalid && arready;
            @(posedge clk); #1;
            if (!rst_n || arhs) begin
                rd_beat = 0; stall_left = 0;
            end else if (hs) begin
                rd_beat++;
                if (rd_beat == stall_at) stall_left = 2;
            end else if (stall_left > 0) begin
                stall_left--;
            end
            rd_data_ready = (stall_left == 0);
        end
    end

    // scoreboard monitor
    initial begin : monitor
        logic        prev_w_stall, prev_done;
        logic [37:0] prev_w;
        logic [39:0] e40;
        logic [36:0] e37;
        logic [32:0] e33;
        logic [2:0]  e3;
        logic [2:0]  act_done;
        prev_w_stall = 1'b0; prev_done = 1'b0; prev_w = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (awvalid && awready) begin
                    if (exp_aw_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL aw_extra: got addr %h len %0d, required no AW", awaddr, awlen);
                    end else begin
                        e40 = exp_aw_q.pop_front();
                        chk("aw", {awaddr, awlen, awsize, awburst}, {e40, 3'd2, 2'b01});
                    end
                end
                if (arvalid && arready) begin
                    if (exp_ar_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL ar_extra: got addr %h len %0d, required no AR", araddr, arlen);
                    end else begin
                        e40 = exp_ar_q.pop_front();
                        chk("ar", {araddr, arlen, arsize, arburst}, {e40, 3'd2, 2'b01});
                    end
                end
                if (wvalid && wready) begin
                    if (exp_w_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL w_extra: got data %h, required no W", wdata);
                    end else begin
                        e37 = exp_w_q.pop_front();
                        chk("w_beat", {wdata, wstrb, wlast}, e37);
                    end
                end
                if (prev_w_stall) chk("w_stable", {wvalid, wdata, wstrb, wlast}, prev_w);
                prev_w_stall = wvalid && !wready;
                prev_w       = {wvalid, wdata, wstrb, wlast};
                if (rd_data_valid && rd_data_ready) begin
                    if (exp_rd_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL rd_extra: got data %h, required no read beat", rd_data);
                    end else begin
                        e33 = exp_rd_q.pop_front();
                        chk("rd_beat", {rd_data, rd_data_last}, e33);
                    end
                end
                if (rvalid && !rd_data_ready) chk("rready_follow", rready, rd_data_ready);
                if (prev_done) chk("done_pulse", done_valid, 1'b0);
                prev_done = done_valid;
                if (done_valid) begin
                    done_cnt++;
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
                    act_done = {done_timeout, done_resp};
`else
                    act_done = {1'b0, done_resp};
`endif
                    if (exp_done_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL done_extra: got resp %b, required no completion", done_resp);
                    end else begin
                        e3 = exp_done_q.pop_front();
                        chk("done_resp", act_done, e3);
                    end
                end
            end else begin
                prev_w_stall = 1'b0; prev_done = 1'b0;
            end
        end
    end

    task automatic issue(input logic wr, input logic [31:0] a, input logic [7:0] l);
        int k = 0;
        while (!cmd_ready && k < 100) begin step(); k++; end
        if (k == 100) begin
            n_vec++; n_err++;
            $display("FAIL cmd_ready_wait: got cmd_ready 0 for 100 cycles, required 1");
        end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int k = 0;
        while (done_cnt == d0 && k < budget) begin step(); k++; end
        n_vec++;
        if (done_cnt == d0) begin
            n_err++;
            $display("FAIL done_wait: got no done_valid in %0d cycles, required one", budget);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        repeat (3) step();
        chk("reset_state", {cmd_ready, awvalid, arvalid, wvalid, wlast, bready, rready,
                            rd_data_valid, rd_data_last, done_valid, wr_data_ready, awaddr, awlen},
            {1'b1, 10'b0, 32'h0, 8'h0});
        rst_n = 1'b1;
        step();

        // single-beat write
        exp_aw_q.push_back({32'h1000, 8'd0});
        exp_w_q.push_back({32'hDEADBEEF, 4'hF, 1'b1});
        exp_done_q.push_back(3'b000);
        wd_q.push_back({32'hDEADBEEF, 4'hF});
        issue(1'b1, 32'h1000, 8'd0);
        wait_done(50);

        // four beats with wready toggling
        w_toggle = 1'b1;
        exp_aw_q.push_back({32'h3000, 8'd3});
        for (int i = 1; i <= 4; i++) begin
            wd_q.push_back({32'(i), 4'hF});
            exp_w_q.push_back({32'(i), 4'hF, (i == 4)});
        end
        exp_done_q.push_back(3'b000);
        issue(1'b1, 32'h3000, 8'd3);
        wait_done(60);
        w_toggle = 1'b0;

        // per-beat strobes, EXOKAY write response
        b_resp_cfg = 2'b01;
        exp_aw_q.push_back({32'h3100, 8'd1});
        wd_q.push_back({32'h55, 4'h3});
        wd_q.push_back({32'h66, 4'hC});
        exp_w_q.push_back({32'h55, 4'h3, 1'b0});
        exp_w_q.push_back({32'h66, 4'hC, 1'b1});
        exp_done_q.push_back(3'b001);
        issue(1'b1, 32'h3100, 8'd1);
        wait_done(50);
        b_resp_cfg = 2'b00;

        // eight-beat read, SLVERR on beat 3, sink stalls at beat 5
        r_beats = 8; r_err_beat = 3; r_base = 32'hA000_0000; stall_at = 5;
        exp_ar_q.push_back({32'h2000, 8'd7});
        for (int i = 0; i < 8; i++) exp_rd_q.push_back({32'hA000_0000 + 32'(i), (i == 7)});
        exp_done_q.push_back(3'b010);
        issue(1'b0, 32'h2000, 8'd7);
        wait_done(80);
        r_err_beat = -1; stall_at = -1;

        // clean four-beat read
        r_beats = 4; r_base = 32'hB000_0000;
        exp_ar_q.push_back({32'h2100, 8'd3});
        for (int i = 0; i < 4; i++) exp_rd_q.push_back({32'hB000_0000 + 32'(i), (i == 3)});
        exp_done_q.push_back(3'b000);
        issue(1'b0, 32'h2100, 8'd3);
        wait_done(50);

        // rlast early (2 beats for len 3) and late (5 beats for len 3)
        r_beats = 2; r_base = 32'hB100_0000;
        exp_ar_q.push_back({32'h2200, 8'd3});
        for (int i = 0; i < 2; i++) exp_rd_q.push_back({32'hB100_0000 + 32'(i), (i == 1)});
        exp_done_q.push_back(3'b010);
        issue(1'b0, 32'h2200, 8'd3);
        wait_done(50);
        r_beats = 5; r_base = 32'hB200_0000;
        exp_ar_q.push_back({32'h2300, 8'd3});
        for (int i = 0; i < 5; i++) exp_rd_q.push_back({32'hB200_0000 + 32'(i), (i == 4)});
        exp_done_q.push_back(3'b010);
        issue(1'b0, 32'h2300, 8'd3);
        wait_done(50);

        // over-length commands: no bus activity, quick SLVERR
        exp_done_q.push_back(3'b010);
        issue(1'b1, 32'h4000, 8'd16);
        wait_done(3);
        exp_done_q.push_back(3'b010);
        issue(1'b0, 32'h4000, 8'd255);
        wait_done(3);

        // reset in the middle of a read
        r_beats = 8; r_base = 32'hC000_0000;
        exp_ar_q.push_back({32'h5000, 8'd7});
        for (int i = 0; i < 8; i++) exp_rd_q.push_back({32'hC000_0000 + 32'(i), (i == 7)});
        issue(1'b0, 32'h5000, 8'd7);
        for (int k = 0; k < 50 && rd_beat < 2; k++) step();
        chk("rd_beat_reach", 64'(rd_beat >= 2), 64'd1);
        rst_n = 1'b0;
        step();
        chk("rst_mid", {cmd_ready, arvalid, rready, rd_data_valid, rd_data_last,
                        done_valid, awvalid, wvalid, bready},
            9'b1_0000_0000);
        rst_n = 1'b1;
        exp_rd_q.delete();
        exp_ar_q.delete();
        step();
        chk("cmd_ready_after_rst", cmd_ready, 1'b1);
        exp_aw_q.push_back({32'h6000, 8'd1});
        wd_q.push_back({32'h1111_2222, 4'hF});
        wd_q.push_back({32'h3333_4444, 4'h5});
        exp_w_q.push_back({32'h1111_2222, 4'hF, 1'b0});
        exp_w_q.push_back({32'h3333_4444, 4'h5, 1'b1});
        exp_done_q.push_back(3'b000);
        issue(1'b1, 32'h6000, 8'd1);
        wait_done(50);

        // awready held low
        aw_ready_cfg = 1'b0;
        step(); step();
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
        exp_done_q.push_back(3'b110);
        issue(1'b1, 32'h7000, 8'd0);
        wait_done(1200);
        chk("aw_dropped", awvalid, 1'b0);
        aw_ready_cfg = 1'b1;
`else
        issue(1'b1, 32'h7000, 8'd0);
        repeat (300) step();
        chk("aw_hold", {awvalid, done_valid}, 2'b10);
        exp_aw_q.push_back({32'h7000, 8'd0});
        wd_q.push_back({32'hCAFE_F00D, 4'hF});
        exp_w_q.push_back({32'hCAFE_F00D, 4'hF, 1'b1});
        exp_done_q.push_back(3'b000);
        aw_ready_cfg = 1'b1;
        wait_done(50);
`endif

        repeat (5) step();
        chk("queues_drained", 64'(exp_aw_q.size() + exp_ar_q.size() + exp_w_q.size() +
                                  exp_rd_q.size() + exp_done_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
